// File: rtl/ccd_adc_readout_if.sv
// ----------------------------------------------------------------------------
// ccd_adc_readout_if
//   Wishbone classic slave bus used by firmware to access the CCD ADC readout
//   block.
//   master modport : drives strobe/cycle/write/select/address/write data,
//                    receives ack and read data.
//   slave modport  : the opposite view, used by ccd_adc_readout.
// ----------------------------------------------------------------------------
interface ccd_adc_readout_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/ccd_adc_readout.sv
// ----------------------------------------------------------------------------
// ccd_adc_readout
//   Runs one serial-ADC conversion per start strobe from the CCD clock
//   generator, tags each sample with its pixel index within the line and
//   buffers the tagged samples in a FIFO that firmware drains over Wishbone.
//
// Ports
//   wb_clk_i               in   single clock for all logic
//   wb_rst_i               in   asynchronous active-high reset
//   wbs                    slave Wishbone bus (registers DATA/STATUS/CTRL)
//   i_adc_start_conversion in   start strobe, asynchronous to wb_clk_i
//   o_adc_cs_n             out  ADC chip select, active low
//   o_adc_sclk             out  ADC serial clock, idles low
//   i_adc_sdo              in   ADC serial data, MSB first
//   o_irq                  out  level interrupt (registered)
//
// Registers
//   DATA   (read)  pop one word: [31] valid, [27:16] pixel index, sample LSBs
//   STATUS (read)  [4:0] count, [8] full, [9] empty, [10] ovf, [11] line_done,
//                  [12] busy, [23:16] overrun count
//          (write) 1 to [10]/[11] clears them; any write zeros overrun count
//   CTRL   [0] enable, [1] flush (self-clearing, reads 0)
// ----------------------------------------------------------------------------
module ccd_adc_readout #(
  parameter int          ADC_BITS        = 12,
  parameter int          SCLK_DIV        = 2,
  parameter int          CONV_WAIT       = 8,
  parameter int          FIFO_DEPTH      = 16,
  parameter int          PIXELS_PER_LINE = 2052,
  parameter logic [31:0] DATA_ADDRESS    = 32'h3000_0020,
  parameter logic [31:0] STATUS_ADDRESS  = 32'h3000_0024,
  parameter logic [31:0] CTRL_ADDRESS    = 32'h3000_0028
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  ccd_adc_readout_if.slave       wbs,
  input  logic                   i_adc_start_conversion,
  output logic                   o_adc_cs_n,
  output logic                   o_adc_sclk,
  input  logic                   i_adc_sdo,
  output logic                   o_irq
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int IDX_W   = 12;
  localparam int ENTRY_W = IDX_W + ADC_BITS;
  localparam int TMR_W   = 16;
  localparam int BIT_W   = $clog2(ADC_BITS + 1);

  localparam logic [TMR_W-1:0] CONV_LOAD   = TMR_W'(CONV_WAIT - 1);
  localparam logic [TMR_W-1:0] PERIOD_LAST = TMR_W'(2 * SCLK_DIV - 1);
  localparam logic [TMR_W-1:0] SCLK_HI     = TMR_W'(SCLK_DIV);
  localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(ADC_BITS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT    = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] HALF_CNT    = CNT_W'(FIFO_DEPTH / 2);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(PIXELS_PER_LINE - 1);

  typedef enum logic [1:0] {IDLE, CONV, SHIFT, STORE} state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t               state, state_n;
  logic [TMR_W-1:0]     tmr, tmr_n;
  logic [BIT_W-1:0]     bit_cnt, bit_n;
  logic [2:0]           start_sync;
  logic [ADC_BITS-1:0]  shreg;
  logic [IDX_W-1:0]     pixel_idx;
  logic                 enable;
  logic                 ovf;
  logic                 line_done;
  logic [7:0]           overrun_cnt;
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     fifo_count;
  logic [ENTRY_W-1:0]   mem [FIFO_DEPTH];

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic                 start_pulse;
  logic                 cs_n_n, sclk_n, sample_en;
  logic                 wb_req, hit_data, hit_status, hit_ctrl, decoded;
  logic                 ctrl_wr, status_wr, data_rd, flush_req;
  logic                 full, empty, pop, store_en, store_fire, push;
  logic [ENTRY_W-1:0]   head;
  logic [31:0]          status_word, rd_data;
  logic                 unused_bits;

  // Start strobe crosses into wb_clk_i through two flops; the third flop
  // remembers the previous synchronised level for rising-edge detection.
  assign start_pulse = start_sync[1] & ~start_sync[2] & enable;

  assign wb_req     = wbs.wbs_stb_i & wbs.wbs_cyc_i & ~wbs.wbs_ack_o;
  assign hit_data   = (wbs.wbs_adr_i == DATA_ADDRESS);
  assign hit_status = (wbs.wbs_adr_i == STATUS_ADDRESS);
  assign hit_ctrl   = (wbs.wbs_adr_i == CTRL_ADDRESS);
  assign decoded    = hit_data | hit_status | hit_ctrl;
  assign ctrl_wr    = wb_req & hit_ctrl & wbs.wbs_we_i;
  assign status_wr  = wb_req & hit_status & wbs.wbs_we_i;
  assign data_rd    = wb_req & hit_data & ~wbs.wbs_we_i;
  assign flush_req  = ctrl_wr & wbs.wbs_dat_i[1];

  assign full  = (fifo_count == FULL_CNT);
  assign empty = (fifo_count == '0);
  assign head  = mem[rd_ptr];
  assign pop   = data_rd & ~empty;

  // A STORE only counts while enabled; a coincident flush discards it.
  assign store_en   = (state == STORE) & enable & ~flush_req;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign store_fire = store_en;
  assign push       = store_fire & (~full | pop);

  assign unused_bits = ^{wbs.wbs_sel_i, wbs.wbs_dat_i[31:12], wbs.wbs_dat_i[9:2]};

  // --------------------------------------------------------------------------
  // Conversion FSM: state register
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state   <= IDLE;
      tmr     <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_n;
      tmr     <= tmr_n;
      bit_cnt <= bit_n;
    end
  end

  // --------------------------------------------------------------------------
  // Conversion FSM: next state and next output levels
  // --------------------------------------------------------------------------
  // NOTE: every signal gets a default before the case, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    tmr_n   = tmr;
    bit_n   = bit_cnt;
    unique case (state)
      IDLE: begin
        if (start_pulse) begin
          state_n = CONV;
          tmr_n   = CONV_LOAD;
        end
      end
      CONV: begin
        if (tmr == '0) begin
          state_n = SHIFT;
          tmr_n   = '0;
          bit_n   = '0;
        end else begin
          tmr_n = tmr - TMR_W'(1);
        end
      end
      SHIFT: begin
        // One SCLK period is 2*SCLK_DIV cycles: low half first, then high.
        if (tmr == PERIOD_LAST) begin
          tmr_n = '0;
          if (bit_cnt == BIT_LAST) state_n = STORE;
          else                     bit_n   = bit_cnt + BIT_W'(1);
        end else begin
          tmr_n = tmr + TMR_W'(1);
        end
      end
      STORE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // Clearing enable abandons whatever conversion is in flight.
    if (!enable) state_n = IDLE;

    // ADC pins are registered from the next state so they never glitch.
    cs_n_n    = !((state_n == CONV) || (state_n == SHIFT));
    sclk_n    = (state_n == SHIFT) && (tmr_n >= SCLK_HI);
    sample_en = (state_n == SHIFT) && (tmr_n == SCLK_HI);
  end

  // --------------------------------------------------------------------------
  // ADC pins, synchroniser and shift register
  // --------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      o_adc_cs_n <= 1'b1;
      o_adc_sclk <= 1'b0;
      start_sync <= '0;
      shreg      <= '0;
    end else begin
      o_adc_cs_n <= cs_n_n;
      o_adc_sclk <= sclk_n;
      start_sync <= {start_sync[1:0], i_adc_start_conversion};
      // SDO is captured on the same edge that raises SCLK.
      if (sample_en) shreg <= {shreg[ADC_BITS-2:0], i_adc_sdo};
    end
  end

  // --------------------------------------------------------------------------
  // FIFO storage
  // --------------------------------------------------------------------------
  // NOTE: the storage array has no reset; validity is tracked solely by the
  // pointers and count, which are reset.
  always_ff @(posedge wb_clk_i) begin
    if (push) mem[wr_ptr] <= {pixel_idx, shreg};
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (flush_req) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Pixel index, sticky flags, overrun counter, control
  // --------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      pixel_idx   <= '0;
      enable      <= 1'b0;
      ovf         <= 1'b0;
      line_done   <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      if (ctrl_wr) enable <= wbs.wbs_dat_i[0];

      // The index advances even when the sample itself is dropped.
      if (flush_req) begin
        pixel_idx <= '0;
      end else if (store_en) begin
        pixel_idx <= (pixel_idx == IDX_LAST) ? '0 : pixel_idx + IDX_W'(1);
      end

      // Setting a sticky flag takes priority over a clear in the same cycle.
      if (store_fire && full && !pop)             ovf <= 1'b1;
      else if (status_wr && wbs.wbs_dat_i[10])    ovf <= 1'b0;

      if (store_en && (pixel_idx == IDX_LAST))    line_done <= 1'b1;
      else if (status_wr && wbs.wbs_dat_i[11])    line_done <= 1'b0;

      if (status_wr) begin
        overrun_cnt <= '0;
      end else if (start_pulse && (state != IDLE) && (overrun_cnt != 8'hFF)) begin
        overrun_cnt <= overrun_cnt + 8'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Register read mux
  // --------------------------------------------------------------------------
  always_comb begin
    status_word        = '0;
    status_word[4:0]   = 5'(fifo_count);
    status_word[8]     = full;
    status_word[9]     = empty;
    status_word[10]    = ovf;
    status_word[11]    = line_done;
    status_word[12]    = (state != IDLE);
    status_word[23:16] = overrun_cnt;
  end

  always_comb begin
    rd_data = '0;
    if (hit_data) begin
      // An empty FIFO reads as all zeros, which also leaves valid clear.
      if (!empty) begin
        rd_data[31]             = 1'b1;
        rd_data[27:16]          = head[ENTRY_W-1:ADC_BITS];
        rd_data[ADC_BITS-1:0]   = head[ADC_BITS-1:0];
      end
    end else if (hit_status) begin
      rd_data = status_word;
    end else if (hit_ctrl) begin
      rd_data[0] = enable;
    end
  end

  // --------------------------------------------------------------------------
  // Wishbone response and interrupt
  // --------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbs.wbs_ack_o <= 1'b0;
      wbs.wbs_dat_o <= '0;
      o_irq         <= 1'b0;
    end else begin
      wbs.wbs_ack_o <= wb_req & decoded;
      if (wb_req && decoded && !wbs.wbs_we_i) wbs.wbs_dat_o <= rd_data;
      o_irq <= enable & ((fifo_count >= HALF_CNT) | line_done | ovf);
    end
  end

endmodule

// File: tb/tb_ccd_adc_readout.sv
// ----------------------------------------------------------------------------
// tb_ccd_adc_readout
//   Self-checking bench for ccd_adc_readout. A small ADC model shifts a chosen
//   word out MSB first; expected DATA words are queued when a conversion is
//   launched and compared when firmware-style reads drain the FIFO. The line
//   length is shortened so the line-wrap case fits in a short run.
// ----------------------------------------------------------------------------
module tb_ccd_adc_readout;

  localparam int          PPL    = 24;
  localparam logic [31:0] DATA_A = 32'h3000_0020;
  localparam logic [31:0] STAT_A = 32'h3000_0024;
  localparam logic [31:0] CTRL_A = 32'h3000_0028;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic sdo = 1'b0;
  logic cs_n, sclk, irq;

  ccd_adc_readout_if bus ();

  ccd_adc_readout #(.PIXELS_PER_LINE(PPL)) dut (
    .wb_clk_i               (clk),
    .wb_rst_i               (rst),
    .wbs                    (bus.slave),
    .i_adc_start_conversion (start),
    .o_adc_cs_n             (cs_n),
    .o_adc_sclk             (sclk),
    .i_adc_sdo              (sdo),
    .o_irq                  (irq)
  );

  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // ADC model: MSB on chip-select fall, next bit after each SCLK fall.
  // --------------------------------------------------------------------------
  logic [11:0] adc_word = '0;
  logic [11:0] adc_shift = '0;
  logic        cs_prev = 1'b1;
  logic        sclk_prev = 1'b0;

  always @(posedge clk) begin
    #1;
    if (cs_prev && !cs_n) begin
      adc_shift = adc_word;
      sdo       = adc_shift[11];
    end else if (sclk_prev && !sclk) begin
      adc_shift = {adc_shift[10:0], 1'b0};
      sdo       = adc_shift[11];
    end
    cs_prev   = cs_n;
    sclk_prev = sclk;
  end

  // --------------------------------------------------------------------------
  // Checking helpers
  // --------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wb_xfer(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic acked);
    @(negedge clk);
    bus.wbs_adr_i = addr;
    bus.wbs_we_i  = we;
    bus.wbs_dat_i = wdata;
    bus.wbs_sel_i = 4'hF;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_cyc_i = 1'b1;
    acked = 1'b0;
    rdata = '0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (bus.wbs_ack_o) begin
        acked = 1'b1;
        rdata = bus.wbs_dat_o;
        break;
      end
    end
    bus.wbs_stb_i = 1'b0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
  endtask

  task automatic rd(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    logic        a;
    wb_xfer(addr, 1'b0, '0, d, a);
    check({name, " ack"}, 32'(a), 32'd1);
    check(name, d, exp);
  endtask

  task automatic wr(input string name, input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] d;
    logic        a;
    wb_xfer(addr, 1'b1, data, d, a);
    check({name, " ack"}, 32'(a), 32'd1);
  endtask

  // Pop n words and compare each against the scoreboard.
  task automatic drain(input int n);
    logic [31:0] d, e;
    logic        a;
    for (int i = 0; i < n; i++) begin
      wb_xfer(DATA_A, 1'b0, '0, d, a);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'h0;
      check("data ack", 32'(a), 32'd1);
      check("data word", d, e);
    end
  endtask

  task automatic start_edge();
    @(negedge clk);
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) for chip select to go low and back high, then let the
  // FIFO write land.
  task automatic wait_done(input string name);
    logic seen_low = 1'b0;
    logic done = 1'b0;
    for (int i = 0; i < 120; i++) begin
      @(posedge clk);
      #1;
      if (!cs_n) seen_low = 1'b1;
      if (seen_low && cs_n) begin
        done = 1'b1;
        break;
      end
    end
    check({name, " finished"}, 32'(done), 32'd1);
    repeat (2) @(posedge clk);
  endtask

  task automatic wait_sclk(input string name);
    logic found = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      if (sclk) begin
        found = 1'b1;
        break;
      end
    end
    check({name, " sclk seen"}, 32'(found), 32'd1);
  endtask

  task automatic convert(input logic [11:0] sample);
    adc_word = sample;
    start_edge();
    wait_done("conversion");
  endtask

  // --------------------------------------------------------------------------
  // Vector table: ADC sample and the DATA word it must produce
  // --------------------------------------------------------------------------
  typedef struct {
    logic [11:0] sample;
    logic [31:0] word;
  } vec_t;

  vec_t vecs [6];

  int   low_at, high_at, rises;
  logic sclk_q;
  logic [11:0] s;

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{12'h000, 32'h8001_0000};
    vecs[1] = '{12'hFFF, 32'h8002_0FFF};
    vecs[2] = '{12'h800, 32'h8003_0800};
    vecs[3] = '{12'h001, 32'h8004_0001};
    vecs[4] = '{12'h555, 32'h8005_0555};
    vecs[5] = '{12'hAAA, 32'h8006_0AAA};

    bus.wbs_stb_i = 1'b0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = '0;
    bus.wbs_adr_i = '0;
    bus.wbs_dat_i = '0;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check("reset cs_n", 32'(cs_n), 32'd1);
    check("reset sclk", 32'(sclk), 32'd0);
    check("reset ack", 32'(bus.wbs_ack_o), 32'd0);
    check("reset dat_o", bus.wbs_dat_o, 32'h0);
    check("reset irq", 32'(irq), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rd("status after reset", STAT_A, 32'h0000_0200);
    begin
      logic [31:0] d;
      logic        a;
      wb_xfer(32'h3000_002C, 1'b0, '0, d, a);
      check("undecoded no ack", 32'(a), 32'd0);
    end
    wr("enable", CTRL_A, 32'h1);
    rd("ctrl readback", CTRL_A, 32'h1);

    // ---- T1: single conversion with latency and SCLK count ----
    adc_word = 12'hA5C;
    low_at = 0; high_at = 0; rises = 0; sclk_q = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int cyc = 1; cyc <= 70; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 3) start = 1'b0;
      if (!cs_n && low_at == 0) low_at = cyc;
      if (low_at != 0 && cs_n && high_at == 0) high_at = cyc;
      if (sclk && !sclk_q) rises++;
      sclk_q = sclk;
    end
    check("t1 cs_n fall cycle", 32'(low_at), 32'd3);
    check("t1 cs_n rise cycle", 32'(high_at), 32'd59);
    check("t1 sclk rises", 32'(rises), 32'd12);
    rd("t1 status count 1", STAT_A, 32'h0000_0001);
    rd("t1 data", DATA_A, 32'h8000_0A5C);
    rd("t1 status empty", STAT_A, 32'h0000_0200);

    // ---- table-driven conversions through the scoreboard ----
    for (int i = 0; i < 6; i++) begin
      convert(vecs[i].sample);
      exp_q.push_back(vecs[i].word);
    end
    rd("table status count 6", STAT_A, 32'h0000_0006);
    check("table irq low", 32'(irq), 32'd0);
    drain(6);
    rd("empty data read", DATA_A, 32'h0);

    // ---- T2: overflow ----
    wr("flush", CTRL_A, 32'h3);
    rd("ctrl flush reads 0", CTRL_A, 32'h1);
    rd("status after flush", STAT_A, 32'h0000_0200);
    for (int i = 0; i < 17; i++) begin
      s = 12'h100 + 12'(i);
      convert(s);
      if (i < 16) exp_q.push_back({1'b1, 3'b000, 12'(i), 4'h0, s});
    end
    rd("t2 status full ovf", STAT_A, 32'h0000_0510);
    check("t2 irq high", 32'(irq), 32'd1);
    wr("t2 clear ovf", STAT_A, 32'h0000_0400);
    rd("t2 status ovf cleared", STAT_A, 32'h0000_0110);
    drain(16);
    repeat (2) @(posedge clk);
    #1;
    check("t2 irq after drain", 32'(irq), 32'd0);
    convert(12'h321);
    exp_q.push_back(32'h8011_0321);
    drain(1);

    // ---- T3: start while busy ----
    adc_word = 12'h0F0;
    @(negedge clk);
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    repeat (17) @(negedge clk);
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_done("t3");
    repeat (70) @(posedge clk);
    rd("t3 status overrun", STAT_A, 32'h0001_0001);
    exp_q.push_back(32'h8012_00F0);
    drain(1);
    wr("t3 status write", STAT_A, 32'h0);
    rd("t3 overrun cleared", STAT_A, 32'h0000_0200);

    // ---- T4: line wrap with continuous draining ----
    wr("t4 flush", CTRL_A, 32'h3);
    for (int i = 0; i <= PPL; i++) begin
      s = 12'(i * 37 + 5);
      convert(s);
      exp_q.push_back({1'b1, 3'b000, 12'(i % PPL), 4'h0, s});
      if (i == PPL - 2) rd("t4 before wrap", STAT_A, 32'h0000_0001);
      if (i == PPL - 1) rd("t4 line_done", STAT_A, 32'h0000_0801);
      drain(1);
    end
    check("t4 irq", 32'(irq), 32'd1);

    // ---- T5: disable during SHIFT ----
    wr("t5 clear line_done", STAT_A, 32'h0000_0800);
    repeat (2) @(posedge clk);
    #1;
    check("t5 irq cleared", 32'(irq), 32'd0);
    adc_word = 12'h3C3;
    start_edge();
    wait_sclk("t5");
    wr("t5 disable", CTRL_A, 32'h0);
    @(posedge clk);
    #1;
    check("t5 abort cs_n", 32'(cs_n), 32'd1);
    check("t5 abort sclk", 32'(sclk), 32'd0);
    repeat (70) @(posedge clk);
    rd("t5 no push", STAT_A, 32'h0000_0200);
    wr("t5 re-enable", CTRL_A, 32'h1);
    convert(12'h3C3);
    exp_q.push_back(32'h8001_03C3);
    drain(1);

    // ---- T6: asynchronous reset mid-SHIFT ----
    adc_word = 12'h777;
    start_edge();
    wait_sclk("t6");
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("t6 cs_n", 32'(cs_n), 32'd1);
    check("t6 sclk", 32'(sclk), 32'd0);
    check("t6 ack", 32'(bus.wbs_ack_o), 32'd0);
    check("t6 dat_o", bus.wbs_dat_o, 32'h0);
    check("t6 irq", 32'(irq), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rd("t6 data after reset", DATA_A, 32'h0);
    rd("t6 ctrl after reset", CTRL_A, 32'h0);
    rd("t6 status after reset", STAT_A, 32'h0000_0200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
